// File: rtl/regfile_dump_unit_pkg.sv
// Shared types and sizing for the register-file dump unit.
// Widths match the integer register file of the core.
package regfile_dump_unit_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_ARCH_REGS  = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_unit_if.sv
// Valid/ready stream of {index, data} beats from the dump unit to the trace bridge.
interface regfile_dump_unit_if;
  import regfile_dump_unit_pkg::*;

  logic                      out_valid;
  logic                      out_ready;
  logic [REG_ADDR_WIDTH-1:0] out_idx;
  logic [XLEN-1:0]           out_data;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_unit.sv
// Walks the register file through a dedicated read port and streams each value out,
// accumulating an XOR signature of every accepted beat.
module regfile_dump_unit
  import regfile_dump_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
  parameter bit          SKIP_X0  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]           rf_rd_data,
  regfile_dump_unit_if.master       out_if,
  output logic                      busy,
  output logic                      done,
  output logic [XLEN-1:0]           signature
);

  localparam logic [REG_ADDR_WIDTH-1:0] FIRST = REG_ADDR_WIDTH'(SKIP_X0);
  localparam logic [REG_ADDR_WIDTH-1:0] LAST  = REG_ADDR_WIDTH'(NUM_REGS - 1);

  dump_state_t               r_state;
  logic [REG_ADDR_WIDTH-1:0] r_idx;
  logic [REG_ADDR_WIDTH-1:0] r_out_idx;
  logic [XLEN-1:0]           r_out_data;
  logic [XLEN-1:0]           r_sig;
  logic                      r_out_valid;
  logic                      r_busy;
  logic                      r_done;
  logic                      w_last;

  // Compare before increment so the index never wraps past LAST.
  assign w_last = (r_idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= DUMP_IDLE;
      r_idx       <= '0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_sig       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      // Also blocks a start arriving in the same cycle while idle.
      r_state     <= DUMP_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        DUMP_IDLE: begin
          if (start) begin
            r_state <= DUMP_LOAD;
            r_idx   <= FIRST;
            r_sig   <= '0;
            r_busy  <= 1'b1;
          end
        end
        DUMP_LOAD: begin
          r_out_data  <= rf_rd_data;
          r_out_idx   <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (out_if.out_ready) begin
            r_sig       <= r_sig ^ r_out_data;
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_state <= DUMP_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + REG_ADDR_WIDTH'(1);
              r_state <= DUMP_LOAD;
            end
          end
        end
        DUMP_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= DUMP_IDLE;
        end
        default: r_state <= DUMP_IDLE;
      endcase
    end
  end

  assign rf_rd_addr       = r_idx;
  assign out_if.out_valid = r_out_valid;
  assign out_if.out_idx   = r_out_idx;
  assign out_if.out_data  = r_out_data;
  assign busy             = r_busy;
  assign done             = r_done;
  assign signature        = r_sig;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: ordering, backpressure, restart, abort, reset, x0 walk.
module tb_regfile_dump_unit;
  import regfile_dump_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  rd_addr, rd_addr0;
  logic [31:0] rd_data, rd_data0;
  logic        busy, done, busy0, done0;
  logic [31:0] sig, sig0;

  logic [31:0] rf [32];
  logic        rf_init = 1'b1;
  logic        wr_en = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [4:0]  beat_idx [64];
  logic [31:0] beat_data [64];
  int          stable_err;

  always #5 clk = ~clk;

  regfile_dump_unit_if dif ();
  regfile_dump_unit_if dif0 ();

  always @(posedge clk) begin
    if (rf_init) begin
      for (int k = 0; k < 32; k++) rf[k] <= 32'h1000_0000 + k;
    end else if (wr_en) begin
      rf[10] <= 32'hDEAD_BEEF;
    end
  end

  assign rd_data  = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];
  assign rd_data0 = (rd_addr0 == 5'd0) ? 32'd0 : rf[rd_addr0];

  regfile_dump_unit #(.NUM_REGS(32), .SKIP_X0(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .rf_rd_addr (rd_addr),
    .rf_rd_data (rd_data),
    .out_if     (dif.master),
    .busy       (busy),
    .done       (done),
    .signature  (sig)
  );

  regfile_dump_unit #(.NUM_REGS(32), .SKIP_X0(1'b0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start0),
    .abort      (1'b0),
    .rf_rd_addr (rd_addr0),
    .rf_rd_data (rd_data0),
    .out_if     (dif0.master),
    .busy       (busy0),
    .done       (done0),
    .signature  (sig0)
  );

  function automatic logic [31:0] golden_sig(input int first, input int last);
    logic [31:0] s = 32'd0;
    for (int k = first; k <= last; k++) s ^= (k == 0) ? 32'd0 : 32'h1000_0000 + k;
    return s;
  endfunction

  // Drives one dump on u_dut and records accepted beats; comparisons live in the test tasks.
  task automatic run_dump(input int stall_idx, input int stall_len, input int wr_idx,
                          input bit extra_start, output int nbeats, output int done_cyc);
    int cyc;
    int stall_cnt;
    nbeats = 0;
    done_cyc = -1;
    stall_cnt = 0;
    stable_err = 0;
    @(negedge clk);
    start = 1'b1;
    dif.out_ready = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      dif.out_ready = 1'b1;
      if (busy && !dif.out_valid && !done && int'(rd_addr) == wr_idx) wr_en = 1'b1;
      if (dif.out_valid && int'(dif.out_idx) == stall_idx && stall_cnt < stall_len) begin
        dif.out_ready = 1'b0;
        stall_cnt++;
        if (dif.out_data !== 32'h1000_0000 + stall_idx) stable_err++;
      end
      if (dif.out_valid && dif.out_ready) begin
        if (nbeats < 64) begin
          beat_idx[nbeats]  = dif.out_idx;
          beat_data[nbeats] = dif.out_data;
        end
        nbeats++;
        if (extra_start && dif.out_idx == 5'd3) start = 1'b1;
      end
      if (done) begin
        done_cyc = cyc;
        if (extra_start) start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic reload_rf();
    @(negedge clk);
    rf_init = 1'b1;
    @(negedge clk);
    rf_init = 1'b0;
  endtask

  task automatic test_reset();
    dif.out_ready = 1'b1;
    dif0.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dif.out_valid, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {dif.out_valid, busy, done});
    else n_pass++;
    n_checks++;
    if ({dif.out_idx, dif.out_data, sig, rd_addr} !== 74'd0) $display("FAIL reset_values: got %h expected 0", {dif.out_idx, dif.out_data, sig, rd_addr});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    rf_init = 1'b0;
  endtask

  task automatic test_full_dump();
    int nb, dc, err;
    run_dump(-1, 0, -1, 1'b0, nb, dc);
    err = 0;
    for (int i = 0; i < 31; i++)
      if (beat_idx[i] !== 5'(i + 1) || beat_data[i] !== 32'h1000_0000 + i + 1) err++;
    n_checks++;
    if (nb !== 31) $display("FAIL full_beats: got %0d expected 31", nb); else n_pass++;
    n_checks++;
    if (err !== 0) $display("FAIL full_order: got %0d bad beats expected 0", err); else n_pass++;
    n_checks++;
    if (dc !== 63) $display("FAIL full_done_cycle: got %0d expected 63", dc); else n_pass++;
    n_checks++;
    if (sig !== golden_sig(1, 31)) $display("FAIL full_signature: got %h expected %h", sig, golden_sig(1, 31));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int nb, dc, err;
    run_dump(7, 5, -1, 1'b0, nb, dc);
    err = 0;
    for (int i = 0; i < 31; i++)
      if (beat_idx[i] !== 5'(i + 1) || beat_data[i] !== 32'h1000_0000 + i + 1) err++;
    n_checks++;
    if (stable_err !== 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err);
    else n_pass++;
    n_checks++;
    if (nb !== 31 || err !== 0) $display("FAIL bp_beats: got %0d beats %0d bad expected 31 0", nb, err);
    else n_pass++;
    n_checks++;
    if (dc !== 68) $display("FAIL bp_done_cycle: got %0d expected 68", dc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nb, dc;
    run_dump(-1, 0, -1, 1'b1, nb, dc);
    n_checks++;
    if (nb !== 31) $display("FAIL b2b_beats: got %0d expected 31", nb); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_no_restart: got busy=%b expected 0", busy); else n_pass++;
    run_dump(-1, 0, -1, 1'b0, nb, dc);
    n_checks++;
    if (nb !== 31 || sig !== golden_sig(1, 31))
      $display("FAIL b2b_fresh_sig: got %0d beats sig %h expected 31 %h", nb, sig, golden_sig(1, 31));
    else n_pass++;
  endtask

  task automatic test_rf_write();
    int nb, dc;
    run_dump(-1, 0, 10, 1'b0, nb, dc);
    n_checks++;
    if (beat_idx[9] !== 5'd10 || beat_data[9] !== 32'h1000_000A)
      $display("FAIL wr_same_load: got idx %0d data %h expected 10 1000000a", beat_idx[9], beat_data[9]);
    else n_pass++;
    reload_rf();
    run_dump(-1, 0, 9, 1'b0, nb, dc);
    n_checks++;
    if (beat_idx[9] !== 5'd10 || beat_data[9] !== 32'hDEAD_BEEF)
      $display("FAIL wr_prev_load: got idx %0d data %h expected 10 deadbeef", beat_idx[9], beat_data[9]);
    else n_pass++;
    reload_rf();
  endtask

  task automatic test_abort();
    int nb, dc, dones;
    bit found;
    found = 1'b0;
    dif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (dif.out_valid && dif.out_idx == 5'd5) begin
        found = 1'b1;
        dif.out_ready = 1'b0;
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    dif.out_ready = 1'b1;
    n_checks++;
    if (!found || {dif.out_valid, busy, done} !== 3'b000)
      $display("FAIL abort_idle: got found=%b flags %b expected 1 000", found, {dif.out_valid, busy, done});
    else n_pass++;
    n_checks++;
    if (sig !== golden_sig(1, 4)) $display("FAIL abort_partial_sig: got %h expected %h", sig, golden_sig(1, 4));
    else n_pass++;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", dones); else n_pass++;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_beats_start: got busy=%b expected 0", busy); else n_pass++;
    run_dump(-1, 0, -1, 1'b0, nb, dc);
    n_checks++;
    if (nb !== 31 || beat_idx[0] !== 5'd1)
      $display("FAIL abort_restart: got %0d beats first idx %0d expected 31 1", nb, beat_idx[0]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    dif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1 || sig === 32'd0) $display("FAIL rst_precond: got busy=%b sig %h expected 1 nonzero", busy, sig);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({dif.out_valid, busy, done, dif.out_idx, dif.out_data, sig, rd_addr} !== 77'd0)
      $display("FAIL rst_async: got %h expected 0", {dif.out_valid, busy, done, dif.out_idx, dif.out_data, sig, rd_addr});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_skip_x0_off();
    int nb, dc, cyc;
    logic [4:0]  first_idx;
    logic [31:0] first_data;
    nb = 0;
    dc = -1;
    first_idx = 5'h1f;
    first_data = 32'hFFFF_FFFF;
    dif0.out_ready = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    cyc = 0;
    while (dc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start0 = 1'b0;
      if (dif0.out_valid) begin
        if (nb == 0) begin
          first_idx = dif0.out_idx;
          first_data = dif0.out_data;
        end
        nb++;
      end
      if (done0) dc = cyc;
    end
    n_checks++;
    if (first_idx !== 5'd0 || first_data !== 32'd0)
      $display("FAIL x0_first_beat: got idx %0d data %h expected 0 0", first_idx, first_data);
    else n_pass++;
    n_checks++;
    if (nb !== 32 || dc !== 65) $display("FAIL x0_count: got %0d beats done %0d expected 32 65", nb, dc);
    else n_pass++;
    n_checks++;
    if (sig0 !== golden_sig(0, 31)) $display("FAIL x0_signature: got %h expected %h", sig0, golden_sig(0, 31));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_back_to_back();
    test_rf_write();
    test_abort();
    test_async_reset();
    test_skip_x0_off();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
